slice_ray_angle_sequencer: RTL and testbench

Per-frame ray-angle generator that sits directly upstream of the fixed-point arithmetic stage.
- On start, walks screen slices 0..NUM_SLICES-1 and emits one ray angle per slice.
- Angle = player_angle - FOV_HALF + slice*0.375 deg, wrapped into 0..359.999.
- Angle format is integer part X plus fractional part Y in thousandths (0..999), the format consumed by fixed_point_subtract_fixed_point.
- Uses an accumulator, not a multiplier; outputs are delivered via a valid/ready handshake.

---
 rtl/slice_ray_angle_sequencer_if.sv | 27 ++
 rtl/slice_ray_angle_sequencer.sv | 149 ++++++++++++++
 tb/tb_slice_ray_angle_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/slice_ray_angle_sequencer_if.sv
// Ray output channel of slice_ray_angle_sequencer: valid/ready handshake
// carrying the slice index and the angle as integer degrees plus thousandths.
interface slice_ray_angle_sequencer_if;
    logic       ray_valid;
    logic       ray_ready;
    logic [7:0] ray_slice;
    logic [9:0] ray_angle_X;
    logic [9:0] ray_angle_Y;

    // Producer side: the sequencer drives the ray, the consumer drives ready.
    modport master (
        output ray_valid,
        output ray_slice,
        output ray_angle_X,
        output ray_angle_Y,
        input  ray_ready
    );

    // Consumer side: the fixed-point arithmetic stage.
    modport slave (
        input  ray_valid,
        input  ray_slice,
        input  ray_angle_X,
        input  ray_angle_Y,
        output ray_ready
    );
endinterface

// File: rtl/slice_ray_angle_sequencer.sv
// slice_ray_angle_sequencer
// Per-frame ray-angle generator. On start it walks slices 0..NUM_SLICES-1 and
// emits one angle per slice: player_angle - FOV_HALF + slice*STEP_FRAC/1000,
// wrapped into 0..359.999, as integer degrees (X) plus thousandths (Y).
// The angle is advanced by an accumulator on each accepted ray; there is no
// multiplier.
// Optional feature: define SLICE_RAY_ABORT_EN to add an abort input that
// cancels a frame in progress (no frame_done pulse is produced).
module slice_ray_angle_sequencer #(
    parameter int NUM_SLICES = 160,
    parameter int STEP_FRAC  = 375,
    parameter int FOV_HALF   = 30
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [8:0]                    player_angle,
`ifdef SLICE_RAY_ABORT_EN
    input  logic                          abort,
`endif
    output logic                          busy,
    output logic                          frame_done,
    slice_ray_angle_sequencer_if.master   ray
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0]  LAST_SLICE = 8'(NUM_SLICES - 1);
    localparam logic [9:0]  FOV        = 10'(FOV_HALF);
    localparam logic [10:0] STEP       = 11'(STEP_FRAC);

    state_t     state, state_nxt;
    logic [7:0] slice_q, slice_nxt;
    logic [9:0] x_q, x_nxt;
    logic [9:0] y_q, y_nxt;
    logic [9:0] x_step, y_step;
    logic       handshake;
    logic       abort_req;

    // First ray angle of a frame: heading minus half the field of view,
    // wrapped below zero back into 0..359. The heading is captured directly
    // into the angle register, so no separate copy of it is kept.
    function automatic logic [9:0] start_angle(input logic [8:0] pa);
        logic [9:0] p;
        p = {1'b0, pa};
        if (p >= FOV)
            return p - FOV;
        else
            return p + 10'd360 - FOV;
    endfunction

    // One accumulator step: add STEP_FRAC thousandths, carry into degrees
    // when the fraction reaches 1000, and wrap 360 back to 0. Y stays below
    // 1000 because both addends are at most 999.
    function automatic logic [19:0] step_angle(input logic [9:0] x,
                                               input logic [9:0] y);
        logic [10:0] s;
        logic [9:0]  nx;
        logic [9:0]  ny;
        s  = {1'b0, y} + STEP;
        nx = x;
        if (s >= 11'd1000) begin
            ny = 10'(s - 11'd1000);
            nx = x + 10'd1;
        end else begin
            ny = s[9:0];
        end
        if (nx == 10'd360)
            nx = 10'd0;
        return {nx, ny};
    endfunction

`ifdef SLICE_RAY_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign handshake        = ray.ray_valid & ray.ray_ready;
    assign {x_step, y_step} = step_angle(x_q, y_q);

    // State and ray registers; reset clears everything, including mid-frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            slice_q <= 8'd0;
            x_q     <= 10'd0;
            y_q     <= 10'd0;
        end else begin
            state   <= state_nxt;
            slice_q <= slice_nxt;
            x_q     <= x_nxt;
            y_q     <= y_nxt;
        end
    end

    // Next-state and ray update; abort outranks a same-cycle handshake, and
    // the last accepted ray keeps its slice/angle visible through DONE.
    always_comb begin
        state_nxt = state;
        slice_nxt = slice_q;
        x_nxt     = x_q;
        y_nxt     = y_q;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = EMIT;
                    slice_nxt = 8'd0;
                    x_nxt     = start_angle(player_angle);
                    y_nxt     = 10'd0;
                end
            end
            EMIT: begin
                if (abort_req) begin
                    state_nxt = IDLE;
                end else if (handshake) begin
                    if (slice_q == LAST_SLICE) begin
                        state_nxt = DONE;
                    end else begin
                        slice_nxt = slice_q + 8'd1;
                        x_nxt     = x_step;
                        y_nxt     = y_step;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Status and ray outputs decoded from the registered state.
    always_comb begin
        ray.ray_valid   = (state == EMIT);
        ray.ray_slice   = slice_q;
        ray.ray_angle_X = x_q;
        ray.ray_angle_Y = y_q;
        busy            = (state != IDLE);
        frame_done      = (state == DONE);
    end

endmodule

// File: tb/tb_slice_ray_angle_sequencer.sv
// Directed testbench for slice_ray_angle_sequencer (default parameters).
// Inputs are driven and outputs sampled on the falling clock edge.
// Build with SLICE_RAY_ABORT_EN defined to include the abort scenario.
module tb_slice_ray_angle_sequencer;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [8:0] player_angle = 9'd0;
`ifdef SLICE_RAY_ABORT_EN
    logic       abort = 1'b0;
`endif
    logic       busy;
    logic       frame_done;

    int total = 0;
    int bad   = 0;

    slice_ray_angle_sequencer_if rif();

    always #5 clock = ~clock;

    slice_ray_angle_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .player_angle (player_angle),
`ifdef SLICE_RAY_ABORT_EN
        .abort        (abort),
`endif
        .busy         (busy),
        .frame_done   (frame_done),
        .ray          (rif.master)
    );

    // Frame capture results (filled by run_frame, checked by the tests).
    logic [9:0] cap_x [256];
    logic [9:0] cap_y [256];
    int         vcount, first_cyc, last_cyc, done_cyc, idle_cyc, done_pulses, seq_err;
    logic [7:0] done_slice;
    logic [9:0] done_x, done_y;
    logic       done_valid;

    // Start a frame with ray_ready held high and record every ray until idle.
    task automatic run_frame(input logic [8:0] pa);
        int cyc;
        for (int i = 0; i < 256; i++) begin
            cap_x[i] = 10'd0;
            cap_y[i] = 10'd0;
        end
        vcount = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1;
        idle_cyc = -1; done_pulses = 0; seq_err = 0;
        done_slice = 8'd0; done_x = 10'd0; done_y = 10'd0; done_valid = 1'b1;
        @(negedge clock);
        player_angle  = pa;
        start         = 1'b1;
        rif.ray_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (cyc = 1; cyc < 400 && idle_cyc < 0; cyc++) begin
            if (rif.ray_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (rif.ray_slice != vcount[7:0]) seq_err++;
                if (vcount < 256) begin
                    cap_x[vcount] = rif.ray_angle_X;
                    cap_y[vcount] = rif.ray_angle_Y;
                end
                vcount++;
                last_cyc = cyc;
            end
            if (frame_done) begin
                if (done_cyc < 0) begin
                    done_cyc   = cyc;
                    done_slice = rif.ray_slice;
                    done_x     = rif.ray_angle_X;
                    done_y     = rif.ray_angle_Y;
                    done_valid = rif.ray_valid;
                end
                done_pulses++;
            end
            if (!busy && idle_cyc < 0) idle_cyc = cyc;
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; rif.ray_ready = 1'b0;
        repeat (2) @(negedge clock);
        total++;
        if (rif.ray_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: valid=%b busy=%b done=%b want 0 0 0",
                     rif.ray_valid, busy, frame_done);
        end
        total++;
        if (rif.ray_slice !== 8'd0 || rif.ray_angle_X !== 10'd0 || rif.ray_angle_Y !== 10'd0) begin
            bad++;
            $display("FAIL reset_data: slice=%0d angle=%0d.%0d want 0 0.0",
                     rif.ray_slice, rif.ray_angle_X, rif.ray_angle_Y);
        end
        reset = 1'b0;
        @(negedge clock);
        total++;
        if (busy !== 1'b0 || rif.ray_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: busy=%b valid=%b want 0 0", busy, rif.ray_valid);
        end
    endtask

    task automatic test_frame_90();
        run_frame(9'd90);
        total++;
        if (idle_cyc < 0) begin
            bad++; $display("FAIL frame90_timeout: never returned to idle");
        end
        total++;
        if (first_cyc != 1) begin
            bad++; $display("FAIL frame90_latency: first valid at %0d want 1", first_cyc);
        end
        total++;
        if (cap_x[0] !== 10'd60 || cap_y[0] !== 10'd0) begin
            bad++; $display("FAIL frame90_s0: got %0d.%0d want 60.0", cap_x[0], cap_y[0]);
        end
        total++;
        if (cap_x[1] !== 10'd60 || cap_y[1] !== 10'd375) begin
            bad++; $display("FAIL frame90_s1: got %0d.%0d want 60.375", cap_x[1], cap_y[1]);
        end
        total++;
        if (cap_x[8] !== 10'd63 || cap_y[8] !== 10'd0) begin
            bad++; $display("FAIL frame90_s8: got %0d.%0d want 63.0", cap_x[8], cap_y[8]);
        end
        total++;
        if (cap_x[159] !== 10'd119 || cap_y[159] !== 10'd625) begin
            bad++; $display("FAIL frame90_s159: got %0d.%0d want 119.625", cap_x[159], cap_y[159]);
        end
        total++;
        if (vcount != 160 || last_cyc != 160 || seq_err != 0) begin
            bad++;
            $display("FAIL frame90_count: valid=%0d last=%0d seq_err=%0d want 160 160 0",
                     vcount, last_cyc, seq_err);
        end
        total++;
        if (done_cyc != 161 || done_pulses != 1 || idle_cyc != 162) begin
            bad++;
            $display("FAIL frame90_done: done_at=%0d pulses=%0d idle_at=%0d want 161 1 162",
                     done_cyc, done_pulses, idle_cyc);
        end
        total++;
        if (done_valid !== 1'b0 || done_slice !== 8'd159 || done_x !== 10'd119 || done_y !== 10'd625) begin
            bad++;
            $display("FAIL frame90_hold: valid=%b slice=%0d angle=%0d.%0d want 0 159 119.625",
                     done_valid, done_slice, done_x, done_y);
        end
    endtask

    task automatic test_wrap_10();
        run_frame(9'd10);
        total++;
        if (cap_x[0] !== 10'd340 || cap_y[0] !== 10'd0) begin
            bad++; $display("FAIL wrap10_s0: got %0d.%0d want 340.0", cap_x[0], cap_y[0]);
        end
        total++;
        if (cap_x[80] !== 10'd10 || cap_y[80] !== 10'd0) begin
            bad++; $display("FAIL wrap10_s80: got %0d.%0d want 10.0", cap_x[80], cap_y[80]);
        end
        total++;
        if (cap_x[159] !== 10'd39 || cap_y[159] !== 10'd625) begin
            bad++; $display("FAIL wrap10_s159: got %0d.%0d want 39.625", cap_x[159], cap_y[159]);
        end
        total++;
        if (vcount != 160 || done_pulses != 1 || seq_err != 0) begin
            bad++;
            $display("FAIL wrap10_count: valid=%0d pulses=%0d seq_err=%0d want 160 1 0",
                     vcount, done_pulses, seq_err);
        end
    endtask

    task automatic test_wrap_359();
        run_frame(9'd359);
        total++;
        if (cap_x[0] !== 10'd329 || cap_y[0] !== 10'd0) begin
            bad++; $display("FAIL wrap359_s0: got %0d.%0d want 329.0", cap_x[0], cap_y[0]);
        end
        total++;
        if (cap_x[82] !== 10'd359 || cap_y[82] !== 10'd750) begin
            bad++; $display("FAIL wrap359_s82: got %0d.%0d want 359.750", cap_x[82], cap_y[82]);
        end
        total++;
        if (cap_x[83] !== 10'd0 || cap_y[83] !== 10'd125) begin
            bad++; $display("FAIL wrap359_s83: got %0d.%0d want 0.125", cap_x[83], cap_y[83]);
        end
        total++;
        if (vcount != 160 || seq_err != 0) begin
            bad++; $display("FAIL wrap359_count: valid=%0d seq_err=%0d want 160 0", vcount, seq_err);
        end
    endtask

    task automatic test_backpressure();
        int   hold_left;
        int   hs;
        int   exp_slice;
        logic held;
        logic finished;
        hold_left = 0; hs = 0; exp_slice = 0; held = 1'b0; finished = 1'b0;
        @(negedge clock);
        player_angle = 9'd90; start = 1'b1; rif.ray_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
            if (rif.ray_valid && hold_left == 0 && rif.ray_slice == 8'd3 && !held) begin
                rif.ray_ready = 1'b0;
                hold_left     = 5;
                held          = 1'b1;
            end else if (hold_left > 0) begin
                total++;
                if (rif.ray_valid !== 1'b1 || rif.ray_slice !== 8'd3 ||
                    rif.ray_angle_X !== 10'd61 || rif.ray_angle_Y !== 10'd125) begin
                    bad++;
                    $display("FAIL bp_hold: valid=%b slice=%0d angle=%0d.%0d want 1 3 61.125",
                             rif.ray_valid, rif.ray_slice, rif.ray_angle_X, rif.ray_angle_Y);
                end
                hold_left--;
                if (hold_left == 0) rif.ray_ready = 1'b1;
            end
            if (rif.ray_valid && rif.ray_ready) begin
                if (rif.ray_slice != exp_slice[7:0]) begin
                    total++; bad++;
                    $display("FAIL bp_seq: slice=%0d want %0d", rif.ray_slice, exp_slice);
                end
                if (rif.ray_slice == 8'd4) begin
                    total++;
                    if (rif.ray_angle_X !== 10'd61 || rif.ray_angle_Y !== 10'd500) begin
                        bad++;
                        $display("FAIL bp_s4: got %0d.%0d want 61.500",
                                 rif.ray_angle_X, rif.ray_angle_Y);
                    end
                end
                exp_slice++;
                hs++;
            end
            if (frame_done) finished = 1'b1;
            @(negedge clock);
        end
        total++;
        if (!finished || hs != 160 || !held) begin
            bad++;
            $display("FAIL bp_total: finished=%b handshakes=%0d held=%b want 1 160 1",
                     finished, hs, held);
        end
    endtask

    task automatic test_start_ignored_reset();
        logic stop;
        stop = 1'b0;
        @(negedge clock);
        player_angle = 9'd90; start = 1'b1; rif.ray_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int cyc = 0; cyc < 400 && !stop; cyc++) begin
            if (rif.ray_valid && rif.ray_slice == 8'd50) begin
                start = 1'b1; player_angle = 9'd200;
                @(negedge clock);
                start = 1'b0;
                total++;
                if (rif.ray_valid !== 1'b1 || busy !== 1'b1 || rif.ray_slice !== 8'd51 ||
                    rif.ray_angle_X !== 10'd79 || rif.ray_angle_Y !== 10'd125) begin
                    bad++;
                    $display("FAIL midstart_ignored: valid=%b slice=%0d angle=%0d.%0d want 1 51 79.125",
                             rif.ray_valid, rif.ray_slice, rif.ray_angle_X, rif.ray_angle_Y);
                end
            end
            if (rif.ray_valid && rif.ray_slice == 8'd100) begin
                total++;
                if (rif.ray_angle_X !== 10'd97 || rif.ray_angle_Y !== 10'd500) begin
                    bad++;
                    $display("FAIL s100_before_reset: got %0d.%0d want 97.500",
                             rif.ray_angle_X, rif.ray_angle_Y);
                end
                reset = 1'b1;
                #1;
                total++;
                if (rif.ray_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 ||
                    rif.ray_slice !== 8'd0 || rif.ray_angle_X !== 10'd0 || rif.ray_angle_Y !== 10'd0) begin
                    bad++;
                    $display("FAIL async_reset: valid=%b busy=%b done=%b slice=%0d angle=%0d.%0d want all 0",
                             rif.ray_valid, busy, frame_done, rif.ray_slice,
                             rif.ray_angle_X, rif.ray_angle_Y);
                end
                stop = 1'b1;
            end
            if (!stop) @(negedge clock);
        end
        total++;
        if (!stop) begin
            bad++; $display("FAIL reset_timeout: slice 100 not reached");
        end
        @(negedge clock);
        reset = 1'b0; player_angle = 9'd45; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        total++;
        if (rif.ray_valid !== 1'b1 || rif.ray_slice !== 8'd0 ||
            rif.ray_angle_X !== 10'd15 || rif.ray_angle_Y !== 10'd0) begin
            bad++;
            $display("FAIL restart_s0: valid=%b slice=%0d angle=%0d.%0d want 1 0 15.0",
                     rif.ray_valid, rif.ray_slice, rif.ray_angle_X, rif.ray_angle_Y);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

`ifdef SLICE_RAY_ABORT_EN
    task automatic test_abort();
        logic hit;
        int   dones;
        hit = 1'b0; dones = 0;
        @(negedge clock);
        player_angle = 9'd90; start = 1'b1; rif.ray_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int cyc = 0; cyc < 300 && !hit; cyc++) begin
            if (rif.ray_valid && rif.ray_slice == 8'd20) hit = 1'b1;
            else @(negedge clock);
        end
        total++;
        if (!hit) begin
            bad++; $display("FAIL abort_timeout: slice 20 not reached");
        end
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        total++;
        if (rif.ray_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle: valid=%b busy=%b done=%b want 0 0 0",
                     rif.ray_valid, busy, frame_done);
        end
        repeat (5) begin
            @(negedge clock);
            if (frame_done) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++; $display("FAIL abort_no_done: frame_done pulses=%0d want 0", dones);
        end
        abort = 1'b1; start = 1'b1; player_angle = 9'd90;
        @(negedge clock);
        abort = 1'b0; start = 1'b0;
        total++;
        if (rif.ray_valid !== 1'b1 || rif.ray_slice !== 8'd0 || rif.ray_angle_X !== 10'd60) begin
            bad++;
            $display("FAIL abort_start_wins: valid=%b slice=%0d X=%0d want 1 0 60",
                     rif.ray_valid, rif.ray_slice, rif.ray_angle_X);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask
`endif

    initial begin
        rif.ray_ready = 1'b0;
        test_reset();
        test_frame_90();
        test_wrap_10();
        test_wrap_359();
        test_backpressure();
        test_start_ignored_reset();
`ifdef SLICE_RAY_ABORT_EN
        test_abort();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
